// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and load/store.
// Load/store has priority; a saturating counter bounds how long fetch can be starved.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [2:0] LAT_C    = 3'(RD_LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic can_grant;
    logic if_win;
    logic ls_win;

    // Fetch only overtakes a waiting load/store once the starvation bound is hit.
    always_comb begin
        can_grant = !reset && (state_q == IDLE || state_q == RESP);
        ls_win    = can_grant && ls_req_i &&
                    !(if_req_i && starve_q == STARVE_C);
        if_win    = can_grant && if_req_i && !ls_win;
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        starve_d   = starve_q;

        if (!if_req_i || if_win) begin
            starve_d = 4'd0;
        end else if (ls_win && starve_q != STARVE_C) begin
            starve_d = starve_q + 4'd1;
        end

        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (if_win || (ls_win && !ls_we_i)) begin
                    state_d = WAIT;
                    lat_d   = LAT_C;
                    owner_d = if_win;
                end
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    state_d = RESP;
                    if (owner_q) begin
                        if_rdata_d = ram_rdata_i;
                    end else begin
                        ls_rdata_d = ram_rdata_i;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= 3'd0;
            starve_q   <= 4'd0;
            owner_q    <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign if_gnt_o    = if_win;
    assign ls_gnt_o    = ls_win;
    assign ram_en_o    = if_win || ls_win;
    assign ram_we_o    = ls_win && ls_we_i;
    assign ram_addr_o  = ls_win ? ls_addr_i : if_addr_i;
    assign ram_wdata_o = ls_wdata_i;

    assign if_rvalid_o = (state_q == RESP) && owner_q;
    assign ls_rvalid_o = (state_q == RESP) && !owner_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RD_LAT=1 instance with a read scoreboard,
// plus an RD_LAT=3 instance for the reset-during-wait case.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;

    logic        if_gnt1, if_rv1, ls_gnt1, ls_rv1;
    logic        ram_en1, ram_we1, busy1;
    logic [31:0] if_rd1, ls_rd1, ram_addr1, ram_wd1;
    logic [31:0] ram_rd1 = '0;

    logic        if_gnt3, if_rv3, ls_gnt3, ls_rv3;
    logic        ram_en3, ram_we3, busy3;
    logic [31:0] if_rd3, ls_rd3, ram_addr3, ram_wd3, ram_rd3;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    bit          wv1  [256];
    bit          wv3  [256];
    logic [31:0] p3   [3];

    mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt1), .if_rvalid_o(if_rv1), .if_rdata_o(if_rd1),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata),
        .ls_gnt_o(ls_gnt1), .ls_rvalid_o(ls_rv1), .ls_rdata_o(ls_rd1),
        .ram_en_o(ram_en1), .ram_we_o(ram_we1), .ram_addr_o(ram_addr1),
        .ram_wdata_o(ram_wd1), .ram_rdata_i(ram_rd1), .busy_o(busy1)
    );

    mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt3), .if_rvalid_o(if_rv3), .if_rdata_o(if_rd3),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata),
        .ls_gnt_o(ls_gnt3), .ls_rvalid_o(ls_rv3), .ls_rdata_o(ls_rd3),
        .ram_en_o(ram_en3), .ram_we_o(ram_we3), .ram_addr_o(ram_addr3),
        .ram_wdata_o(ram_wd3), .ram_rdata_i(ram_rd3), .busy_o(busy3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(logic [7:0] i);
        case (i)
            8'd192:  return 32'hAAAA5555;
            8'd193:  return 32'h12345678;
            default: return 32'h1000_0000 | {24'd0, i};
        endcase
    endfunction

    function automatic logic [31:0] rd1(logic [7:0] i);
        return wv1[i] ? mem1[i] : dflt(i);
    endfunction

    function automatic logic [31:0] rd3(logic [7:0] i);
        return wv3[i] ? mem3[i] : dflt(i);
    endfunction

    // RAM models: RD_LAT=1 registered read, RD_LAT=3 three-stage pipe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en1) begin
            if (ram_we1) begin
                mem1[ram_addr1[9:2]] <= ram_wd1;
                wv1[ram_addr1[9:2]]  <= 1'b1;
            end else begin
                ram_rd1 <= rd1(ram_addr1[9:2]);
            end
        end
        if (ram_en3 && ram_we3) begin
            mem3[ram_addr3[9:2]] <= ram_wd3;
            wv3[ram_addr3[9:2]]  <= 1'b1;
        end
        if (ram_en3 && !ram_we3) begin
            p3[0] <= rd3(ram_addr3[9:2]);
        end
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_rd3 = p3[2];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push: every RAM read granted by the RD_LAT=1 instance.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            sb.delete();
        end else if (ram_en1 && !ram_we1) begin
            sb.push_back('{is_if: if_gnt1,
                           data: rd1(ram_addr1[9:2]),
                           due: cyc + 2});
        end
    end

    // Scoreboard pop: check owner, data and latency of each response.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (if_rv1 || ls_rv1) begin
                if (sb.size() == 0) begin
                    chk("rv_unexpected", {if_rv1, ls_rv1}, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rv_owner", if_rv1, e.is_if);
                    chk("rv_single", ls_rv1, !e.is_if);
                    chk("rv_data", e.is_if ? if_rd1 : ls_rd1, e.data);
                    chk("rv_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("rv_missing", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        #1;
        while (busy1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", busy1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a pending fetch.
        if_req  = 1'b1;
        if_addr = 32'h40;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_if_gnt", if_gnt1, 1'b0);
            chk("rst_ls_gnt", ls_gnt1, 1'b0);
            chk("rst_ram_en", ram_en1, 1'b0);
            chk("rst_busy", busy1, 1'b0);
        end
        chk("rst_rvalid", {if_rv1, ls_rv1}, 2'b00);
        chk("rst_if_rdata", if_rd1, 32'h0);
        chk("rst_ls_rdata", ls_rd1, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_if_gnt", if_gnt1, 1'b1);
        chk("rel_ram_en", ram_en1, 1'b1);
        chk("rel_ram_we", ram_we1, 1'b0);
        chk("rel_ram_addr", ram_addr1, 32'h40);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("rel_busy", busy1, 1'b1);
        chk("rel_no_rv", if_rv1, 1'b0);
        @(negedge clk);
        #1;
        chk("rel_if_rv", if_rv1, 1'b1);
        chk("rel_if_rdata", if_rd1, 32'h1000_0010);
        wait_idle();

        // Load beats fetch; fetch goes in the response cycle.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h80;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h100;
        #1;
        chk("pri_ls_gnt", ls_gnt1, 1'b1);
        chk("pri_if_gnt", if_gnt1, 1'b0);
        chk("pri_addr", ram_addr1, 32'h100);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        chk("pri_wait_gnt", {if_gnt1, ls_gnt1}, 2'b00);
        @(negedge clk);
        #1;
        chk("pri_ls_rv", ls_rv1, 1'b1);
        chk("pri_ls_rdata", ls_rd1, 32'h1000_0040);
        chk("pri_resp_if_gnt", if_gnt1, 1'b1);
        chk("pri_resp_addr", ram_addr1, 32'h80);
        @(negedge clk);
        if_req = 1'b0;
        wait_idle();

        // Back-to-back stores.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ls_req   = 1'b1;
            ls_we    = 1'b1;
            ls_addr  = 32'(32'h10 + 4 * k);
            ls_wdata = 32'(32'h5000 + k);
            #1;
            chk("st_gnt", ls_gnt1, 1'b1);
            chk("st_we", ram_we1, 1'b1);
            chk("st_addr", ram_addr1, 32'(32'h10 + 4 * k));
            chk("st_wdata", ram_wd1, 32'(32'h5000 + k));
            chk("st_busy", busy1, 1'b0);
            chk("st_rv", {if_rv1, ls_rv1}, 2'b00);
        end
        @(negedge clk);
        ls_req = 1'b0;
        ls_we  = 1'b0;
        #1;
        chk("st_after_busy", busy1, 1'b0);

        // Starvation: four stores, then fetch, twice.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if_req   = 1'b1;
                if_addr  = 32'h200;
                ls_req   = 1'b1;
                ls_we    = 1'b1;
                ls_addr  = 32'h20;
                ls_wdata = 32'h77;
            end
            #1;
            chk("sv1_ls_gnt", ls_gnt1, k < 4);
            chk("sv1_if_gnt", if_gnt1, k == 4);
        end
        @(negedge clk);
        if_addr = 32'h204;
        #1;
        chk("sv_wait_gnt", {if_gnt1, ls_gnt1}, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("sv2_ls_gnt", ls_gnt1, k < 4);
            chk("sv2_if_gnt", if_gnt1, k == 4);
        end
        @(negedge clk);
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
        wait_idle();

        // Read data routed to the right requester and held.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h300;
        #1;
        chk("rt_if_gnt", if_gnt1, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rt_if_rv", if_rv1, 1'b1);
        chk("rt_if_rdata", if_rd1, 32'hAAAA5555);
        @(negedge clk);
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h304;
        #1;
        chk("rt_ls_gnt", ls_gnt1, 1'b1);
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rt_ls_rv", ls_rv1, 1'b1);
        chk("rt_ls_rdata", ls_rd1, 32'h12345678);
        chk("rt_if_hold", if_rd1, 32'hAAAA5555);
        wait_idle();

        // Reset during WAIT on the RD_LAT=3 instance.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h40;
        #1;
        chk("rw_gnt", if_gnt3, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        reset  = 1'b1;
        #1;
        chk("rw_busy_pre", busy3, 1'b1);
        chk("rw_gnt_forced", if_gnt3, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_busy_post", busy3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("rw_no_rv", if_rv3, 1'b0);
            chk("rw_idle", busy3, 1'b0);
        end
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h44;
        #1;
        chk("rw_new_gnt", if_gnt3, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk("rw_lat_rv", if_rv3, 1'b0);
            chk("rw_lat_busy", busy3, 1'b1);
        end
        @(negedge clk);
        #1;
        chk("rw_rv", if_rv3, 1'b1);
        chk("rw_rdata", if_rd3, 32'h1000_0011);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port RAM between the instruction-fetch requester (IF) and the load/store requester (LS).
- Grants one access per slot and tracks the single outstanding read.
- Routes read data back to the requester that issued the read.
- Sits between the fetch/memory units and the RAM macro; data accesses take priority, with a starvation bound that protects fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 1, RAM read latency in cycles, from enable to valid ram_rdata_i; legal range 1..4
STARVE_MAX, 4, maximum consecutive LS grants while IF is waiting; legal range 1..15

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
if_req_i  in  1  fetch read request; held, with if_addr_i stable, until if_gnt_o
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  one-cycle pulse: if_rdata_o is valid
if_rdata_o  out  DATA_W  fetch read data
ls_req_i  in  1  load/store request; held, with its address and data stable, until ls_gnt_o
ls_we_i  in  1  1 = store, 0 = load
ls_addr_i  in  ADDR_W  load/store address
ls_wdata_i  in  DATA_W  store data
ls_gnt_o  out  1  load/store request accepted this cycle
ls_rvalid_o  out  1  one-cycle pulse: ls_rdata_o is valid
ls_rdata_o  out  DATA_W  load data
ram_en_o  out  1  RAM access enable
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_W  RAM address
ram_wdata_o  out  DATA_W  RAM write data
ram_rdata_i  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_en_o with ram_we_o=0
busy_o  out  1  a read is outstanding

Behaviour:
- Reset values:
  - All gnt, rvalid, ram_en and ram_we outputs are 0; all rdata outputs are 0; busy_o is 0.
  - State is IDLE, the latency counter is 0 and the starvation counter is 0.
  - While reset is high, all gnt and ram_en outputs are forced to 0.
- State IDLE (accepts a grant):
  - Grant is combinational. In the grant cycle, ram_en_o=1 and ram_addr_o, ram_we_o and ram_wdata_o come from the winner's inputs.
  - For an IF grant, ram_we_o=0.
- Arbitration when both requesters are waiting:
  - LS wins, unless the starvation counter equals STARVE_MAX; then IF wins.
  - With only one request pending, that request is granted.
  - At most one gnt is high per cycle.
- Starvation counter (saturating):
  - Increments on every LS grant made while if_req_i=1.
  - Clears on an IF grant, or in any cycle where if_req_i=0.
- Stores:
  - A granted store completes in its grant cycle and produces no rvalid.
  - The arbiter stays in IDLE, so back-to-back stores are accepted every cycle.
- Reads:
  - On a granted read, the owner register records IF or LS, the latency counter loads RD_LAT and the state moves to WAIT.
  - busy_o=1 from the cycle after the grant until the rvalid cycle inclusive.
- State WAIT (no grants):
  - The latency counter decrements each cycle.
  - When it reaches 0, ram_rdata_i is captured into the owner's rdata register and the state moves to RESP.
- State RESP:
  - The owner's rvalid is 1 for exactly one cycle; its rdata holds the captured value.
  - A new grant is allowed in this same cycle, following the IDLE rules; the state goes to WAIT after a read grant, otherwise to IDLE.
- Latency and throughput:
  - A read's rvalid arrives RD_LAT+1 cycles after its gnt cycle.
  - Sustained read throughput is one read per RD_LAT+1 cycles.
- rdata hold: each rdata output holds its last value until the next rvalid for that requester. It is never overwritten by the other requester's read.
- Requester obligations:
  - A requester must not drop req before its gnt.
  - A new request from the owner may be presented during WAIT; it is granted no earlier than RESP.
- Reset mid-operation: an outstanding read is dropped, no rvalid is emitted, and both counters clear.
- Address and data are passed through unmodified; the arbiter performs no alignment or width checks.

Test Plan:
- Reset with RD_LAT=1: hold reset 3 cycles while if_req_i=1 -> no gnt and ram_en_o=0 throughout. Release reset -> if_gnt_o=1 in the first cycle after release and ram_addr_o=if_addr_i; if_rvalid_o is high 2 cycles later with if_rdata_o=ram_rdata_i.
- Fixed priority: if_req_i and ls_req_i (load at 0x100) both high in IDLE -> ls_gnt_o=1 and if_gnt_o=0. ls_rvalid_o occurs with the RAM word at 0x100. IF is granted in that RESP cycle.
- Back-to-back stores: 3 consecutive stores to 0x10, 0x14, 0x18 -> ls_gnt_o=1 on 3 consecutive cycles, ram_we_o=1 each cycle, no rvalid, busy_o stays 0.
- Starvation with STARVE_MAX=4: ls_req_i and if_req_i held high continuously -> exactly 4 LS grants, then an IF grant, and the counter clears.
- Data routing: IF read of 0xAAAA5555 followed by an LS read of 0x12345678 -> if_rdata_o holds 0xAAAA5555 after ls_rvalid_o, and ls_rdata_o=0x12345678.
- Reset in WAIT with RD_LAT=3: assert reset 1 cycle after an IF read grant -> no if_rvalid_o and busy_o=0. A new request after reset is granted in its first cycle.
